// File: rtl/dj8_bus_arbiter_if.sv
// Request/ack channel between one bus master and the DJ8 bus arbiter.
interface dj8_bus_arbiter_if;
  logic        req;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  wdata;
  logic        ack;

  // Master side: issues requests and receives the completion pulse.
  modport master (output req, addr, we, wdata, input ack);
  // Arbiter side: samples requests and returns the completion pulse.
  modport slave  (input req, addr, we, wdata, output ack);
endinterface

// File: rtl/dj8_bus_arbiter.sv
// DJ8 bus arbiter: shares the multiplexed external pin bus and on-chip ROM
// between the CPU (m0) and the debug/loader port (m1).
module dj8_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          RR          = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  dj8_bus_arbiter_if.slave    m0,
  dj8_bus_arbiter_if.slave    m1,
  output logic [7:0]          rdata,
  output logic [6:0]          ext_addr_hi,
  output logic                ext_we,
  output logic [7:0]          ext_ad,
  output logic                ext_write_cycle,
  input  logic [7:0]          ext_din,
  output logic [7:0]          rom_addr,
  input  logic [7:0]          rom_data
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ROM, ACK} state_t;

  state_t              state;
  logic                prio_m1;
  logic                winner_m1;
  logic                lat_we;
  logic [DATA_W-1:0]   lat_wdata;
  logic [CNT_W-1:0]    wait_cnt;
  logic                ack0_q;
  logic                ack1_q;

  logic                any_req_c;
  logic                grant_m1_c;
  logic [ADDR_W-1:0]   win_addr_c;
  logic                win_we_c;
  logic [DATA_W-1:0]   win_wdata_c;

  // Winner selection: m1 wins only when alone or when round-robin favours it.
  assign any_req_c   = m0.req | m1.req;
  assign grant_m1_c  = m1.req & (~m0.req | (RR & prio_m1));
  assign win_addr_c  = grant_m1_c ? m1.addr  : m0.addr;
  assign win_we_c    = grant_m1_c ? m1.we    : m0.we;
  assign win_wdata_c = grant_m1_c ? m1.wdata : m0.wdata;

  assign m0.ack = ack0_q;
  assign m1.ack = ack1_q;

  // Transaction sequencer with registered pin, ROM, ack and read-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      prio_m1         <= 1'b0;
      winner_m1       <= 1'b0;
      lat_we          <= 1'b0;
      lat_wdata       <= '0;
      wait_cnt        <= '0;
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      rdata           <= '0;
      ext_addr_hi     <= '0;
      ext_we          <= 1'b0;
      ext_ad          <= '0;
      ext_write_cycle <= 1'b0;
      rom_addr        <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            winner_m1 <= grant_m1_c;
            prio_m1   <= ~grant_m1_c;
            lat_we    <= win_we_c;
            lat_wdata <= win_wdata_c;
            wait_cnt  <= CNT_W'(WAIT_CYCLES);
            if (win_addr_c[ADDR_W-1]) begin
              state    <= ROM;
              rom_addr <= win_addr_c[7:0];
            end else begin
              state           <= ADDR;
              ext_ad          <= win_addr_c[7:0];
              ext_addr_hi     <= win_addr_c[14:8];
              ext_we          <= win_we_c;
              ext_write_cycle <= 1'b0;
            end
          end
        end
        ADDR: begin
          state <= DATA;
          if (lat_we) begin
            ext_ad          <= lat_wdata;
            ext_write_cycle <= 1'b1;
          end
        end
        DATA: begin
          if (wait_cnt == '0) begin
            if (!lat_we) rdata <= ext_din;
            ext_ad          <= '0;
            ext_addr_hi     <= '0;
            ext_we          <= 1'b0;
            ext_write_cycle <= 1'b0;
            ack0_q          <= ~winner_m1;
            ack1_q          <= winner_m1;
            state           <= ACK;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        ROM: begin
          if (!lat_we) rdata <= rom_data;
          ack0_q <= ~winner_m1;
          ack1_q <= winner_m1;
          state  <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
